// File: rtl/delay_ctrl_pkg.sv
// Shared types and defaults for the tapped delay line controller.
package delay_ctrl_pkg;

    localparam int DEF_NUM_STAGS  = 256;
    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_SAMPLE_CNT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_DONE
    } state_t;

    // Bits needed to encode n distinct values, never less than one.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/delay_tap_decode.sv
// Registered tap decoder: tap n enables stages below n and loops back at stage n.
module delay_tap_decode
    import delay_ctrl_pkg::*;
#(
    parameter int NUM_STAGS = DEF_NUM_STAGS,
    parameter int TAP_W     = clog2w(NUM_STAGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TAP_W-1:0]     tap,
    output logic [NUM_STAGS-1:0] on,
    output logic [NUM_STAGS-1:0] lb
);

    localparam logic [NUM_STAGS-1:0] ONE = NUM_STAGS'(1);

    logic [NUM_STAGS-1:0] lb_next;
    logic [NUM_STAGS-1:0] on_next;

    // One-hot loopback at the tap; all lower stages forward (2^n - 1).
    always_comb begin
        lb_next = ONE << tap;
        on_next = lb_next - ONE;
    end

    // Register the decoded enables; reset parks the line at tap 0.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on <= '0;
            lb <= ONE;
        end else begin
            on <= on_next;
            lb <= lb_next;
        end
    end

endmodule

// File: rtl/delay_tap_ctrl.sv
// Tap sequencer: direct tap set plus a calibration scan that finds the first
// tap whose majority vote differs from the tap-0 vote.
module delay_tap_ctrl
    import delay_ctrl_pkg::*;
#(
    parameter int NUM_STAGS  = DEF_NUM_STAGS,
    parameter int TAP_W      = clog2w(NUM_STAGS),
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int SAMPLE_CNT = DEF_SAMPLE_CNT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [TAP_W-1:0]     cfg_tap,
    input  logic                 scan_start,
    output logic                 scan_busy,
    output logic                 scan_done,
    output logic                 scan_found,
    output logic [TAP_W-1:0]     scan_tap,
    input  logic                 sample_in,
    output logic [TAP_W-1:0]     cur_tap,
    output logic [NUM_STAGS-1:0] on,
    output logic [NUM_STAGS-1:0] lb
);

    localparam int SET_W  = clog2w(SETTLE_CYC + 1);
    localparam int ONES_W = clog2w(SAMPLE_CNT + 1);

    localparam logic [TAP_W-1:0]  LAST_TAP   = TAP_W'(NUM_STAGS - 1);
    localparam logic [SET_W-1:0]  SET_LAST   = SET_W'(SETTLE_CYC);
    localparam logic [ONES_W-1:0] SAMP_LAST  = ONES_W'(SAMPLE_CNT - 1);
    localparam logic [ONES_W-1:0] HALF_CNT   = ONES_W'(SAMPLE_CNT / 2);

    state_t             state, state_next;
    logic [TAP_W-1:0]   tap_cnt;
    logic [TAP_W-1:0]   saved_tap;
    logic [TAP_W-1:0]   cfg_tap_sat;
    logic [SET_W-1:0]   settle_cnt;
    logic [ONES_W-1:0]  sample_cnt;
    logic [ONES_W-1:0]  ones_cnt;
    logic               ref_vote;
    logic               vote;
    logic               edge_hit;
    logic               last_tap;
    logic               cfg_fire;

    // A simultaneous scan_start takes priority, so cfg is held off that cycle.
    assign cfg_ready = (state == ST_IDLE) && !scan_start;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign scan_busy = (state != ST_IDLE);
    assign scan_done = (state == ST_DONE);

    // Tie (exactly half ones) votes 0.
    assign vote     = (ones_cnt > HALF_CNT);
    assign edge_hit = (tap_cnt != '0) && (vote != ref_vote);
    assign last_tap = (tap_cnt == LAST_TAP);

    if (NUM_STAGS < (1 << TAP_W)) begin : g_clamp
        // Out-of-range tap codes saturate at the last stage.
        always_comb cfg_tap_sat = (cfg_tap > LAST_TAP) ? LAST_TAP : cfg_tap;
    end else begin : g_pass
        assign cfg_tap_sat = cfg_tap;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    // NOTE: assigning the default first keeps every path covered, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (scan_start) state_next = ST_APPLY;
            ST_APPLY:  state_next = ST_SETTLE;
            // First SETTLE cycle is the decoder register update, then SETTLE_CYC more.
            ST_SETTLE: if (settle_cnt == SET_LAST) state_next = ST_SAMPLE;
            ST_SAMPLE: if (sample_cnt == SAMP_LAST) state_next = ST_EVAL;
            ST_EVAL:   state_next = (edge_hit || last_tap) ? ST_DONE : ST_APPLY;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Tap, counters, vote reference and scan result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_tap    <= '0;
            tap_cnt    <= '0;
            saved_tap  <= '0;
            settle_cnt <= '0;
            sample_cnt <= '0;
            ones_cnt   <= '0;
            ref_vote   <= 1'b0;
            scan_found <= 1'b0;
            scan_tap   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (scan_start) begin
                        saved_tap <= cur_tap;
                        tap_cnt   <= '0;
                    end else if (cfg_fire) begin
                        cur_tap <= cfg_tap_sat;
                    end
                end
                ST_APPLY: begin
                    cur_tap    <= tap_cnt;
                    settle_cnt <= '0;
                    sample_cnt <= '0;
                    ones_cnt   <= '0;
                end
                ST_SETTLE: begin
                    if (settle_cnt != SET_LAST) settle_cnt <= settle_cnt + SET_W'(1);
                end
                ST_SAMPLE: begin
                    ones_cnt   <= ones_cnt + ONES_W'(sample_in);
                    sample_cnt <= sample_cnt + ONES_W'(1);
                end
                ST_EVAL: begin
                    if (tap_cnt == '0) ref_vote <= vote;
                    // Result is latched here so it is already valid while scan_done is high.
                    if (edge_hit) begin
                        scan_found <= 1'b1;
                        scan_tap   <= tap_cnt;
                    end else if (last_tap) begin
                        scan_found <= 1'b0;
                        scan_tap   <= LAST_TAP;
                    end else begin
                        tap_cnt <= tap_cnt + TAP_W'(1);
                    end
                end
                ST_DONE: begin
                    cur_tap <= scan_found ? scan_tap : saved_tap;
                end
                default: ;
            endcase
        end
    end

    delay_tap_decode #(
        .NUM_STAGS(NUM_STAGS),
        .TAP_W    (TAP_W)
    ) u_decode (
        .clk  (clk),
        .rst_n(rst_n),
        .tap  (cur_tap),
        .on   (on),
        .lb   (lb)
    );

endmodule
